// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Loads hit with zero latency; misses freeze the pipeline while a dirty victim is written back and the line refilled.
module dcache_controller #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 start_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WRD_W  = $clog2(LINE_BITS / 32);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int BASE_W = $clog2(LINE_BITS);

  typedef enum logic [1:0] {IDLE, WRITEBACK, READMISS, READMISSOK} state_e;

  state_e                 state_q, state_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [LINES-1:0]       dirty_q, dirty_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [LINE_BITS-1:0]   data_q [LINES];

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       req_tag;
  logic [WRD_W-1:0]       wsel;
  logic [BASE_W-1:0]      wbase;
  logic                   req, hit, idle_hit;
  logic                   fill, store;
  logic                   unused_addr_bits;

  // The CPU holds the request stable during a stall, so fields are decoded live.
  assign idx              = cpu_addr_i[OFF_W +: IDX_W];
  assign req_tag          = cpu_addr_i[31 -: TAG_W];
  assign wsel             = cpu_addr_i[2 +: WRD_W];
  assign wbase            = {wsel, 5'b0};
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit      = req & valid_q[idx] & (tag_q[idx] == req_tag);
  assign idle_hit = (state_q == IDLE) & hit;

  assign cpu_stall_o = req & ~idle_hit;
  assign cpu_data_o  = idle_hit ? data_q[idx][wbase +: 32] : 32'h0;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = '0;
    case (state_q)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, {OFF_W{1'b0}}};
        mem_data_o   = data_q[idx];
      end
      READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, {OFF_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    fill    = 1'b0;
    store   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : READMISS;
        end else if (hit && cpu_MemWrite_i) begin
          store        = 1'b1;
          dirty_d[idx] = 1'b1;
        end
      end
      WRITEBACK: if (mem_ack_i) state_d = READMISS;
      READMISS: begin
        if (mem_ack_i) begin
          state_d      = READMISSOK;
          fill         = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
        end
      end
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag and data arrays are not reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx]  <= req_tag;
    end else if (store) begin
      data_q[idx][wbase +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a line-level cache/memory model predicts every output each cycle,
// directed scenarios pin the model with literal values, then randomized traffic exercises hits, evictions and latencies.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         start_i;
  logic [31:0]  cpu_addr_i, cpu_data_i;
  logic         cpu_MemRead_i, cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i          (clk_i),
    .start_i        (start_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cache lines plus a sparse backing memory keyed by line address.
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_data  [16];
  logic [255:0] mem_m   [bit [26:0]];

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    if (!mem_m.exists(a[31:5])) mem_m[a[31:5]] = rand_line();
    return mem_m[a[31:5]];
  endfunction

  // Per-cycle expectations consumed by the compare process.
  bit           chk_en = 1'b0;
  bit           exp_stall, exp_en, exp_wr, chk_rdata;
  logic [31:0]  exp_addr, exp_rdata;
  logic [255:0] exp_wdata;

  task automatic set_exp(input bit stall, input bit en, input bit wr, input logic [31:0] a,
                         input logic [255:0] d, input bit cd, input logic [31:0] rd);
    exp_stall = stall; exp_en = en; exp_wr = wr; exp_addr = a;
    exp_wdata = d; chk_rdata = cd; exp_rdata = rd;
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("stall",      256'(cpu_stall_o),  256'(exp_stall));
      check("mem_enable", 256'(mem_enable_o), 256'(exp_en));
      check("mem_write",  256'(mem_write_o),  256'(exp_wr));
      check("mem_addr",   256'(mem_addr_o),   256'(exp_addr));
      check("mem_data",   mem_data_o,         exp_wdata);
      if (chk_rdata) check("cpu_data", 256'(cpu_data_o), 256'(exp_rdata));
    end
  end

  // Observations of the last request, used by the literal checks.
  int          n_stall;
  bit          saw_write;
  logic [31:0] cap_wb_addr, cap_wb_w1, cap_rd_addr, cap_rdata;

  task automatic step();
    @(negedge clk_i);
    if (cpu_stall_o) n_stall++;
    if (mem_enable_o && mem_write_o) begin
      saw_write   = 1'b1;
      cap_wb_addr = mem_addr_o;
      cap_wb_w1   = mem_data_o[63:32];
    end
    if (mem_enable_o && !mem_write_o) cap_rd_addr = mem_addr_o;
    if (!cpu_stall_o) cap_rdata = cpu_data_o;
    @(posedge clk_i);
    #1;
  endtask

  // One CPU access; lat = idle memory cycles before the ack cycle of each memory transaction.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input bit rd, input bit wr,
                        input int lat);
    int          idx = int'(addr[8:5]);
    int          w   = int'(addr[4:2]);
    logic [22:0] tag = addr[31:9];
    logic [31:0] vaddr;
    n_stall = 0; saw_write = 1'b0;
    cap_wb_addr = '0; cap_wb_w1 = '0; cap_rd_addr = '0; cap_rdata = '0;
    cpu_addr_i = addr; cpu_data_i = wdata; cpu_MemRead_i = rd; cpu_MemWrite_i = wr;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      set_exp(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      mem_ack_i = 1'($urandom_range(0, 1));
      step();
      if (m_valid[idx] && m_dirty[idx]) begin
        vaddr = {m_tag[idx], addr[8:5], 5'b0};
        for (int c = 0; c <= lat; c++) begin
          set_exp(1'b1, 1'b1, 1'b1, vaddr, m_data[idx], 1'b0, '0);
          mem_ack_i  = (c == lat);
          mem_data_i = rand_line();
          step();
        end
        mem_m[vaddr[31:5]] = m_data[idx];
      end
      vaddr = {tag, addr[8:5], 5'b0};
      for (int c = 0; c <= lat; c++) begin
        set_exp(1'b1, 1'b1, 1'b0, vaddr, '0, 1'b0, '0);
        mem_ack_i  = (c == lat);
        mem_data_i = (c == lat) ? mem_line(vaddr) : rand_line();
        step();
      end
      m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tag; m_data[idx] = mem_line(vaddr);
      set_exp(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      mem_ack_i = 1'($urandom_range(0, 1));
      step();
    end
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, rd && !wr, m_data[idx][32*w +: 32]);
    mem_ack_i = ($urandom_range(0, 3) == 0);
    step();
    mem_ack_i = 1'b0;
    if (wr) begin
      m_data[idx][32*w +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    cpu_addr_i = $urandom; cpu_data_i = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
    mem_ack_i = 1'($urandom_range(0, 1));
    step();
    mem_ack_i = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l;
    logic [22:0]  tags [4];
    logic [31:0]  a;
    int           kind;
    tags[0] = 23'h000000; tags[1] = 23'h000001; tags[2] = 23'h7FFFFF; tags[3] = 23'h2AAAAA;

    start_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    clear_model();
    #1;
    check("reset_en",    256'(mem_enable_o), 256'(0));
    check("reset_wr",    256'(mem_write_o),  256'(0));
    check("reset_addr",  256'(mem_addr_o),   256'(0));
    check("reset_wdata", mem_data_o,         256'(0));
    check("reset_stall", 256'(cpu_stall_o),  256'(0));
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_hold_en", 256'(mem_enable_o), 256'(0));
    start_i = 1'b1;
    chk_en  = 1'b1;

    l = rand_line(); l[31:0] = 32'h1111_1111; mem_m[27'h2]  = l;
    l = rand_line(); l[31:0] = 32'h2222_2222; mem_m[27'h12] = l;

    // Cold load: 1 IDLE miss cycle + 11 READMISS cycles (ack on the 11th) + READMISSOK.
    do_req(32'h0000_0040, 32'h0, 1'b1, 1'b0, 10);
    check("cold_stall_cycles", 256'(n_stall),     256'(13));
    check("cold_fill_addr",    256'(cap_rd_addr), 256'(32'h40));
    check("cold_no_write",     256'(saw_write),   256'(0));
    check("cold_data",         256'(cap_rdata),   256'(32'h1111_1111));

    do_req(32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b1, 2);
    check("store_hit_stall", 256'(n_stall), 256'(0));
    do_req(32'h0000_0044, 32'h0, 1'b1, 1'b0, 2);
    check("load_hit_stall", 256'(n_stall),   256'(0));
    check("load_hit_data",  256'(cap_rdata), 256'(32'hDEAD_BEEF));

    do_req(32'h0000_0240, 32'h0, 1'b1, 1'b0, 3);
    check("evict_wb_seen",  256'(saw_write),   256'(1));
    check("evict_wb_addr",  256'(cap_wb_addr), 256'(32'h40));
    check("evict_wb_word1", 256'(cap_wb_w1),   256'(32'hDEAD_BEEF));
    check("evict_rd_addr",  256'(cap_rd_addr), 256'(32'h240));
    check("evict_data",     256'(cap_rdata),   256'(32'h2222_2222));

    do_req(32'h0000_0440, 32'h0, 1'b1, 1'b0, 2);
    check("clean_evict_no_write", 256'(saw_write),   256'(0));
    check("clean_evict_rd_addr",  256'(cap_rd_addr), 256'(32'h440));

    do_req(32'h0000_0448, 32'h1234_5678, 1'b1, 1'b1, 2);
    check("rdwr_store_stall", 256'(n_stall), 256'(0));
    do_req(32'h0000_0040, 32'h0, 1'b1, 1'b0, 0);
    check("rdwr_dirty_wb",   256'(saw_write),   256'(1));
    check("rdwr_wb_addr",    256'(cap_wb_addr), 256'(32'h440));
    check("refetch_word0",   256'(cap_rdata),   256'(32'h1111_1111));
    do_req(32'h0000_0044, 32'h0, 1'b1, 1'b0, 0);
    check("refetch_word1",   256'(cap_rdata),   256'(32'hDEAD_BEEF));
    do_req(32'h0000_0044, 32'hCAFE_F00D, 1'b0, 1'b1, 0);
    idle_cycle();

    // Abort a READMISS with reset; the dirty line at index 2 must be discarded.
    chk_en = 1'b0;
    cpu_addr_i = 32'h0000_0060; cpu_data_i = '0; cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b0;
    mem_ack_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("abort_pre_en", 256'(mem_enable_o), 256'(1));
    #2 start_i = 1'b0;
    #1;
    check("abort_en_async",   256'(mem_enable_o), 256'(0));
    check("abort_addr_async", 256'(mem_addr_o),   256'(0));
    @(posedge clk_i);
    #1;
    check("abort_hold_en", 256'(mem_enable_o), 256'(0));
    start_i = 1'b1;
    clear_model();
    chk_en = 1'b1;
    do_req(32'h0000_0060, 32'h0, 1'b1, 1'b0, 1);
    check("abort_reload_miss", 256'(n_stall > 0), 256'(1));
    do_req(32'h0000_0044, 32'h0, 1'b1, 1'b0, 1);
    check("abort_dirty_dropped", 256'(saw_write), 256'(0));
    check("abort_mem_word1",     256'(cap_rdata), 256'(32'hDEAD_BEEF));

    for (int i = 0; i < 300; i++) begin
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 2);
      do_req(a, $urandom, kind != 1, kind != 0, $urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have parameter LINES, default 16, meaning the number of direct-mapped cache lines; the index width is log2(LINES).
REQ-002 The block SHALL have parameter LINE_BITS, default 256, meaning the line size in bits (32 bytes, 8 words).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_i, input, 1: the single clock.
- start_i, input, 1: asynchronous active-low reset; 0 = reset.
- cpu_addr_i, input, 32: MEM-stage byte address, word aligned.
- cpu_data_i, input, 32: store data.
- cpu_MemRead_i, input, 1: load request.
- cpu_MemWrite_i, input, 1: store request.
- cpu_data_o, output, 32: load data.
- cpu_stall_o, output, 1: freeze the whole pipeline.
- mem_addr_o, output, 32: line-aligned memory address.
- mem_data_o, output, 256: writeback line.
- mem_enable_o, output, 1: memory request valid.
- mem_write_o, output, 1: 1 = line write, 0 = line read.
- mem_data_i, input, 256: fill line.
- mem_ack_i, input, 1: single-cycle completion pulse.

Function
REQ-005 The address split SHALL be: tag = [31:9] (23 bits), index = [8:5], word = [4:2]; bits [1:0] SHALL be ignored.
REQ-006 Each line SHALL hold valid, dirty, a 23-bit tag and 256 bits of data; word w SHALL occupy data bits [32w+31:32w].
REQ-007 A request SHALL be cpu_MemRead_i | cpu_MemWrite_i; if both are asserted, the request SHALL be treated as a store.
REQ-008 A hit SHALL be defined as request & valid[index] & (tag[index] == addr tag).
REQ-009 Load hit: cpu_data_o SHALL present the selected word combinationally in the same cycle, with cpu_stall_o = 0 (zero-latency).
REQ-010 Store hit: the selected word SHALL be written at the next rising edge and dirty set to 1, with cpu_stall_o = 0.
REQ-011 When there is no request, cpu_data_o SHALL be 0, cpu_stall_o = 0, and no state changes.
REQ-012 cpu_stall_o SHALL equal request & ~(state == IDLE & hit), combinationally; a miss therefore stalls in the same cycle it is presented.
REQ-013 The FSM SHALL have states IDLE, WRITEBACK, READMISS and READMISSOK, with these transitions:
- IDLE → WRITEBACK on miss when valid & dirty.
- IDLE → READMISS on miss otherwise.
- WRITEBACK → READMISS on mem_ack_i.
- READMISS → READMISSOK on mem_ack_i.
- READMISSOK → IDLE unconditionally.
REQ-014 In WRITEBACK, the block SHALL drive:
- mem_enable_o = 1 and mem_write_o = 1;
- mem_addr_o = {stored tag, index, 5'b0};
- mem_data_o = stored line.
These SHALL be held until ack.
REQ-015 In READMISS, the block SHALL drive mem_enable_o = 1, mem_write_o = 0 and mem_addr_o = {request tag, index, 5'b0}, held until ack.
REQ-016 On the READMISS ack edge, the block SHALL set line data = mem_data_i, tag = request tag, valid = 1 and dirty = 0.
REQ-017 After READMISSOK, the held request SHALL re-evaluate as a hit in IDLE, per REQ-009/010; a store then sets dirty.
REQ-018 In IDLE and READMISSOK, mem_enable_o and mem_write_o SHALL be 0; mem_addr_o and mem_data_o SHALL be 0 whenever mem_enable_o = 0.
REQ-019 mem_ack_i SHALL be ignored in IDLE and READMISSOK.
REQ-020 The CPU holds cpu_addr_i, cpu_data_i and the request stable while cpu_stall_o = 1; the block SHALL NOT latch request fields.
REQ-021 Only one memory transaction SHALL be outstanding at a time; a writeback SHALL always complete before its fill is issued.
REQ-022 Memory latency SHALL be unbounded; the FSM SHALL wait indefinitely for mem_ack_i.

Reset
REQ-023 While start_i = 0, the block SHALL hold: state = IDLE, all valid and dirty bits = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
REQ-024 Reset SHALL act immediately, without a clock edge.
REQ-025 Tag and data arrays SHALL NOT require reset.
REQ-026 Reset asserted mid-transaction SHALL abort it: the FSM returns to IDLE, mem_enable_o drops asynchronously, and dirty data is discarded.
REQ-027 After reset release, the first request SHALL always miss.

Verification
REQ-028 Cold load: after reset, load 0x0000_0040 with memory line word0 = 0x1111_1111. Required response:
- stall is 1 in the same cycle;
- READMISS is issued with mem_addr_o = 0x40 and mem_write_o = 0;
- ack arrives after 10 cycles;
- stall deasserts 2 cycles after ack, with cpu_data_o = 0x1111_1111.
REQ-029 Store hit: store 0xDEAD_BEEF to 0x44 after REQ-028. Required response:
- no stall;
- a following load of 0x44 returns 0xDEAD_BEEF with zero stall;
- the line is dirty.
REQ-030 Dirty eviction: load 0x0000_0240 (same index 2, different tag). Required response:
- WRITEBACK is issued with mem_addr_o = 0x40, mem_write_o = 1, and mem_data_o word1 = 0xDEAD_BEEF;
- after its ack, READMISS is issued with mem_addr_o = 0x240;
- the load returns the fill word.
REQ-031 Clean eviction: a miss on a clean valid line SHALL go directly to READMISS, with no write observed.
REQ-032 Reset during READMISS: pull start_i low with mem_enable_o = 1. Required response:
- mem_enable_o = 0 immediately;
- after release, a re-load of the same address misses again.
REQ-033 Simultaneous cpu_MemRead_i and cpu_MemWrite_i on a hit SHALL perform the store, with dirty = 1 and no stall.
